// File: rtl/keyboard_pkg.sv
// Shared decoder types and PS/2 scan-code constants for the keyboard event path.
package keyboard_pkg;

   localparam int unsigned EventWidth = 10;

   localparam logic [7:0] CodeExt   = 8'hE0;
   localparam logic [7:0] CodeRel   = 8'hF0;
   localparam logic [7:0] CodeErrLo = 8'h00;
   localparam logic [7:0] CodeErrHi = 8'hFF;

   typedef enum logic [1:0] {
      StIdle,
      StExt,
      StRel,
      StExtRel
   } dec_state_e;

endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through FIFO; a push while full is only accepted alongside a pop.
module event_fifo #(
   parameter int unsigned Depth = 16,
   parameter int unsigned Width = 10,
   localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_push,
   input  logic [Width-1:0] i_data,
   input  logic             i_pop,
   output logic [Width-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [AddrW:0]   o_count
);

   logic [Width-1:0] r_mem [Depth];
   logic [AddrW-1:0] r_wr_ptr;
   logic [AddrW-1:0] r_rd_ptr;
   logic [AddrW:0]   r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == (AddrW + 1)'(Depth));
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge clock) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers wrap naturally because Depth is a power of two.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AddrW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AddrW'(1);
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + (AddrW + 1)'(1);
         end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - (AddrW + 1)'(1);
         end
      end
   end

endmodule

// File: rtl/keyboard_event_ctrl.sv
// PS/2 scan-byte decoder: folds E0/F0 prefixes into {release, extended, code} events
// and queues them in an event FIFO with a sticky overflow flag.
module keyboard_event_ctrl
   import keyboard_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 16,
   parameter int unsigned PREFIX_TIMEOUT = 1000000,
   localparam int unsigned CountW        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [7:0]            keyboard_code,
   input  logic                  keyboard_strobe,
   output logic [EventWidth-1:0] kbd_data,
   output logic                  kbd_valid,
   input  logic                  kbd_read,
   output logic [CountW-1:0]     kbd_count,
   output logic                  kbd_overflow,
   input  logic                  overflow_clear
);

   localparam int unsigned TmoW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
   localparam logic [TmoW-1:0] TmoLast = TmoW'(PREFIX_TIMEOUT - 1);

   dec_state_e            r_state;
   dec_state_e            w_next;
   logic [TmoW-1:0]       r_tmo;
   logic                  r_overflow;
   logic                  w_is_event;
   logic                  w_push;
   logic                  w_rel;
   logic                  w_ext;
   logic [EventWidth-1:0] w_event;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_drop;

   assign w_rel   = (r_state == StRel) || (r_state == StExtRel);
   assign w_ext   = (r_state == StExt) || (r_state == StExtRel);
   assign w_event = {w_rel, w_ext, keyboard_code};
   assign w_push  = keyboard_strobe & w_is_event;

   // A repeated prefix restarts the sequence rather than being silently absorbed.
   always_comb begin
      w_is_event = 1'b0;
      w_next     = r_state;
      if (keyboard_code == CodeErrLo || keyboard_code == CodeErrHi) begin
         w_next = StIdle;
      end else if (keyboard_code == CodeExt) begin
         w_next = StExt;
      end else if (keyboard_code == CodeRel) begin
         w_next = (r_state == StExt) ? StExtRel : StRel;
      end else begin
         w_is_event = 1'b1;
         w_next     = StIdle;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= StIdle;
         r_tmo   <= '0;
      end else if (keyboard_strobe) begin
         r_state <= w_next;
         r_tmo   <= '0;
      end else if (r_state != StIdle) begin
         if (r_tmo == TmoLast) begin
            r_state <= StIdle;
            r_tmo   <= '0;
         end else begin
            r_tmo <= r_tmo + TmoW'(1);
         end
      end else begin
         r_tmo <= '0;
      end
   end

   event_fifo #(
      .Depth (FIFO_DEPTH),
      .Width (EventWidth)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (w_event),
      .i_pop   (kbd_read),
      .o_data  (kbd_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (kbd_count)
   );

   assign kbd_valid = ~w_empty;
   assign w_drop    = w_push & w_full & ~(kbd_read & kbd_valid);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (overflow_clear) begin
         r_overflow <= 1'b0;
      end
   end

   assign kbd_overflow = r_overflow;

endmodule

// File: doc/keyboard_event_ctrl.md
KEYBOARD_EVENT_CTRL -- requirements
Module: keyboard_event_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, event FIFO entries; power of two, 2..64.
REQ-002 SHALL have parameter PREFIX_TIMEOUT, default 1000000, clock cycles a partial prefix sequence may wait for its next byte (10 ms at 100 MHz).
REQ-003 SHALL have port clock, input, 1, 100 MHz system clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port keyboard_code, input, 8, received PS/2 scan byte; valid only with strobe.
REQ-006 SHALL have port keyboard_strobe, input, 1, single-cycle pulse marking a new keyboard_code.
REQ-007 SHALL have port kbd_data, output, 10, head event {release, extended, code[7:0]}.
REQ-008 SHALL have port kbd_valid, output, 1, FIFO not empty.
REQ-009 SHALL have port kbd_read, input, 1, pop head event this cycle.
REQ-010 SHALL have port kbd_count, output, clog2(FIFO_DEPTH)+1, occupancy.
REQ-011 SHALL have port kbd_overflow, output, 1, sticky dropped-event flag.
REQ-012 SHALL have port overflow_clear, input, 1, clears kbd_overflow.

Function
REQ-013 SHALL run a decoder FSM with states IDLE, EXT (E0 seen), REL (F0 seen), EXT_REL (E0 then F0 seen).
REQ-014 SHALL act only on cycles with keyboard_strobe=1; other cycles hold state, except for the timeout counter.
REQ-015 SHALL transition IDLE+0xE0->EXT, IDLE+0xF0->REL, EXT+0xF0->EXT_REL.
REQ-016 SHALL, on any other byte, push {rel,ext,byte} and return to IDLE; rel=1 in REL/EXT_REL and ext=1 in EXT/EXT_REL.
REQ-017 SHALL discard bytes 0x00 and 0xFF (keyboard error) in any state and return to IDLE without pushing.
REQ-018 SHALL treat 0xE0 in EXT/REL/EXT_REL and 0xF0 in REL/EXT_REL as protocol errors: no push, next state EXT or REL respectively (restart sequence).
REQ-019 SHALL count cycles in non-IDLE states; reaching PREFIX_TIMEOUT with no strobe returns FSM to IDLE with no push; the counter reloads on every strobe.
REQ-020 SHALL push at the rising edge ending the strobe cycle; kbd_valid and kbd_data reflect the event in the next cycle (latency 1).
REQ-021 SHALL present the head entry on kbd_data whenever kbd_valid=1 (first-word-fall-through); kbd_data is don't-care when empty.
REQ-022 SHALL pop on kbd_read=1 with kbd_valid=1; kbd_read when empty is ignored.
REQ-023 SHALL, on push when full without simultaneous pop, drop the new event, leave contents unchanged, and set kbd_overflow.
REQ-024 SHALL, on simultaneous push and pop, perform both regardless of fullness; count unchanged, no overflow.
REQ-025 SHALL wrap read/write pointers modulo FIFO_DEPTH; kbd_count=FIFO_DEPTH when full.
REQ-026 SHALL give set priority over overflow_clear when both occur in one cycle.

Reset
REQ-027 SHALL on reset force FSM=IDLE, pointers=0, timeout counter=0, kbd_count=0, kbd_valid=0, kbd_overflow=0; storage contents need not be reset.
REQ-028 SHALL discard any partial prefix sequence and all queued events on reset mid-operation; first strobe after reset release decodes from IDLE.

Structure
REQ-029 SHALL place decoder state enum, event word width (10), and constants 0xE0, 0xF0, 0x00, 0xFF in shared package keyboard_pkg.
REQ-030 SHALL implement the FIFO as one sub-module event_fifo (parameterised depth/width, push/pop/full/empty/count); decoder FSM stays in keyboard_event_ctrl.
REQ-031 SHALL be instantiated directly after keyboard_if, consuming its keyboard_code/keyboard_strobe unchanged.

Verification
REQ-032 SHALL cover: strobes 0x1C -> one event kbd_data=0x01C, kbd_valid next cycle.
REQ-033 SHALL cover: strobes 0xE0,0xF0,0x75 -> one event 0x375; strobes 0xF0,0x1C -> 0x21C.
REQ-034 SHALL cover: 0xE0 then PREFIX_TIMEOUT idle cycles then 0x1C -> event 0x01C (not extended).
REQ-035 SHALL cover: 17 events with no reads (depth 16) -> kbd_count=16, kbd_overflow=1, head is first event; 17th push with simultaneous kbd_read -> no overflow.
REQ-036 SHALL cover: 0xF0, 0xFF, 0x1C -> single event 0x01C; kbd_read when empty -> kbd_count stays 0.
REQ-037 SHALL cover: reset asserted after 0xE0 with 3 events queued -> kbd_valid=0 immediately, next 0x1C yields 0x01C.
